// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and lane widths for the SDRAM port arbiter.
package wb_port_arbiter_pkg;

   localparam int unsigned ADR_W     = 32;
   localparam int unsigned DAT_W     = 32;
   localparam int unsigned SEL_W     = 4;
   localparam int unsigned BW_W      = 4;
   localparam int unsigned MAX_PORTS = 8;
   localparam int unsigned MAX_IDX_W = 3;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_GRANT   = 2'd1,
      ARB_RELEASE = 2'd2
   } arb_state_e;

   // Snoop write payload broadcast to the non-writing ports.
   typedef struct packed {
      logic [ADR_W-1:0] adr;
      logic [DAT_W-1:0] dat;
      logic [SEL_W-1:0] sel;
   } bufw_payload_t;

   // One-hot mask for a port index, sized for the largest supported port count.
   function automatic logic [MAX_PORTS-1:0] port_onehot(input logic [MAX_IDX_W-1:0] idx);
      return MAX_PORTS'(1) << idx;
   endfunction

endpackage

// File: rtl/wb_port_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester searching upward, with wrap,
// starting one past the last granted port.
module rr_arbiter
   import wb_port_arbiter_pkg::*;
#(
   parameter int unsigned NUM_PORTS  = 3,
   parameter int unsigned PORT_IDX_W = $clog2(NUM_PORTS)
) (
   input  logic [NUM_PORTS-1:0]  req_i,
   input  logic [PORT_IDX_W-1:0] last_grant_i,
   output logic [PORT_IDX_W-1:0] grant_idx_o,
   output logic                  grant_vld_o
);

   logic [PORT_IDX_W-1:0] cand;

   // Scan offsets 1..NUM_PORTS from the last grant; the first hit wins.
   always_comb begin
      grant_idx_o = '0;
      grant_vld_o = 1'b0;
      cand        = '0;
      for (int unsigned off = 1; off <= NUM_PORTS; off++) begin
         cand = PORT_IDX_W'((32'(last_grant_i) + off) % NUM_PORTS);
         if (!grant_vld_o && req_i[cand]) begin
            grant_vld_o = 1'b1;
            grant_idx_o = cand;
         end
      end
   end

endmodule

// File: rtl/wb_port_arbiter.sv
// Round-robin sharing of one SDRAM controller interface among NUM_PORTS
// Wishbone port buffers. Completed writes are optionally broadcast to the
// other ports' buffer-write inputs when WB_PORT_ARBITER_BUFW_EN is defined;
// otherwise the bufw_* outputs are tied to zero.
module wb_port_arbiter
   import wb_port_arbiter_pkg::*;
#(
   parameter int unsigned NUM_PORTS  = 3,
   parameter int unsigned PORT_IDX_W = $clog2(NUM_PORTS)
) (
   input  logic                        sdram_clk,
   input  logic                        sdram_rst,
   input  logic [NUM_PORTS-1:0]        p_acc_i,
   input  logic [NUM_PORTS-1:0]        p_we_i,
   input  logic [ADR_W*NUM_PORTS-1:0]  p_adr_i,
   input  logic [DAT_W*NUM_PORTS-1:0]  p_dat_i,
   input  logic [SEL_W*NUM_PORTS-1:0]  p_sel_i,
   input  logic [BW_W*NUM_PORTS-1:0]   p_buf_width_i,
   output logic [NUM_PORTS-1:0]        p_ack_o,
   output logic [DAT_W-1:0]            p_dat_o,
   output logic [ADR_W-1:0]            p_adr_o,
   output logic                        acc_o,
   output logic                        we_o,
   output logic [ADR_W-1:0]            adr_o,
   output logic [DAT_W-1:0]            dat_o,
   output logic [SEL_W-1:0]            sel_o,
   output logic [BW_W-1:0]             buf_width_o,
   input  logic                        ack_i,
   input  logic [DAT_W-1:0]            dat_i,
   input  logic [ADR_W-1:0]            adr_i,
   output logic [ADR_W-1:0]            bufw_adr_o,
   output logic [DAT_W-1:0]            bufw_dat_o,
   output logic [SEL_W-1:0]            bufw_sel_o,
   output logic [NUM_PORTS-1:0]        bufw_we_o,
   output logic [PORT_IDX_W-1:0]       grant_o
);

   arb_state_e            state_q, state_d;
   logic [PORT_IDX_W-1:0] grant_q, grant_d;
   logic [PORT_IDX_W-1:0] last_grant_q, last_grant_d;
   logic                  acc_q, acc_d;
   logic                  we_q, we_d;

   logic [PORT_IDX_W-1:0] pick_idx;
   logic                  pick_vld;
   logic [NUM_PORTS-1:0]  grant_mask;

   logic [ADR_W-1:0]      adr_g;
   logic [DAT_W-1:0]      dat_g;
   logic [SEL_W-1:0]      sel_g;
   logic [BW_W-1:0]       bw_g;

`ifdef WB_PORT_ARBITER_BUFW_EN
   logic [NUM_PORTS-1:0]  bufw_we_q, bufw_we_d;
   bufw_payload_t         bufw_pl_q, bufw_pl_d;
`endif

   rr_arbiter #(
      .NUM_PORTS  (NUM_PORTS),
      .PORT_IDX_W (PORT_IDX_W)
   ) u_rr (
      .req_i        (p_acc_i),
      .last_grant_i (last_grant_q),
      .grant_idx_o  (pick_idx),
      .grant_vld_o  (pick_vld)
   );

   // Lanes of the currently granted port.
   always_comb begin
      adr_g = p_adr_i[32'(grant_q)*ADR_W +: ADR_W];
      dat_g = p_dat_i[32'(grant_q)*DAT_W +: DAT_W];
      sel_g = p_sel_i[32'(grant_q)*SEL_W +: SEL_W];
      bw_g  = p_buf_width_i[32'(grant_q)*BW_W +: BW_W];
   end

   assign grant_mask = NUM_PORTS'(port_onehot(MAX_IDX_W'(grant_q)));

   // Next-state and next-output computation for the arbitration FSM.
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      acc_d        = acc_q;
      we_d         = we_q;
`ifdef WB_PORT_ARBITER_BUFW_EN
      bufw_we_d    = '0;
      bufw_pl_d    = bufw_pl_q;
`endif
      unique case (state_q)
         ARB_IDLE: begin
            if (pick_vld) begin
               grant_d = pick_idx;
               acc_d   = 1'b1;
               we_d    = p_we_i[pick_idx];
               state_d = ARB_GRANT;
            end
         end
         ARB_GRANT: begin
            if (!p_acc_i[grant_q]) begin
               // Requester left (read done or abandoned access): no snoop.
               acc_d        = 1'b0;
               we_d         = 1'b0;
               last_grant_d = grant_q;
               state_d      = ARB_RELEASE;
            end else if (we_q && ack_i) begin
               // A write completes on its first ack.
               acc_d        = 1'b0;
               we_d         = 1'b0;
               last_grant_d = grant_q;
               state_d      = ARB_RELEASE;
`ifdef WB_PORT_ARBITER_BUFW_EN
               bufw_we_d    = ~grant_mask;
               bufw_pl_d    = '{adr: adr_g, dat: dat_g, sel: sel_g};
`endif
            end
         end
         ARB_RELEASE: begin
            state_d = ARB_IDLE;
         end
         default: begin
            state_d = ARB_IDLE;
            acc_d   = 1'b0;
            we_d    = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge sdram_clk) begin
      if (sdram_rst) begin
         state_q      <= ARB_IDLE;
         grant_q      <= '0;
         last_grant_q <= PORT_IDX_W'(NUM_PORTS - 1);
         acc_q        <= 1'b0;
         we_q         <= 1'b0;
`ifdef WB_PORT_ARBITER_BUFW_EN
         bufw_we_q    <= '0;
         bufw_pl_q    <= '0;
`endif
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         acc_q        <= acc_d;
         we_q         <= we_d;
`ifdef WB_PORT_ARBITER_BUFW_EN
         bufw_we_q    <= bufw_we_d;
         bufw_pl_q    <= bufw_pl_d;
`endif
      end
   end

   // Ack is routed only to the owner while a grant is active.
   always_comb begin
      p_ack_o = '0;
      if (state_q == ARB_GRANT && ack_i) begin
         p_ack_o = grant_mask;
      end
   end

   assign p_dat_o     = dat_i;
   assign p_adr_o     = adr_i;
   assign acc_o       = acc_q;
   assign we_o        = we_q;
   assign adr_o       = adr_g;
   assign dat_o       = dat_g;
   assign sel_o       = sel_g;
   assign buf_width_o = bw_g;
   assign grant_o     = grant_q;

`ifdef WB_PORT_ARBITER_BUFW_EN
   assign bufw_we_o  = bufw_we_q;
   assign bufw_adr_o = bufw_pl_q.adr;
   assign bufw_dat_o = bufw_pl_q.dat;
   assign bufw_sel_o = bufw_pl_q.sel;
`else
   assign bufw_we_o  = '0;
   assign bufw_adr_o = '0;
   assign bufw_dat_o = '0;
   assign bufw_sel_o = '0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed steps followed by random
// traffic, compared each cycle against a behavioural arbitration model.
module tb_wb_port_arbiter;

   localparam int N = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst;
   logic [N-1:0]     p_acc, p_we;
   logic [32*N-1:0]  p_adr, p_dat;
   logic [4*N-1:0]   p_sel, p_bw;
   logic [N-1:0]     p_ack_o;
   logic [31:0]      p_dat_o, p_adr_o;
   logic             acc_o, we_o;
   logic [31:0]      adr_o, dat_o;
   logic [3:0]       sel_o, buf_width_o;
   logic             ack_i;
   logic [31:0]      dat_i, adr_i;
   logic [31:0]      bufw_adr_o, bufw_dat_o;
   logic [3:0]       bufw_sel_o;
   logic [N-1:0]     bufw_we_o;
   logic [1:0]       grant_o;

   // Per-port agent state
   logic        a_req[N];
   logic        a_we[N];
   logic [31:0] a_adr[N];
   logic [31:0] a_dat[N];
   logic [3:0]  a_sel[N];
   logic [3:0]  a_bw[N];
   int          left_acks[N];
   bit          done_f[N];

   for (genvar g = 0; g < N; g++) begin : g_pack
      assign p_acc[g]          = a_req[g];
      assign p_we[g]           = a_we[g];
      assign p_adr[g*32 +: 32] = a_adr[g];
      assign p_dat[g*32 +: 32] = a_dat[g];
      assign p_sel[g*4 +: 4]   = a_sel[g];
      assign p_bw[g*4 +: 4]    = a_bw[g];
   end

   wb_port_arbiter #(.NUM_PORTS(N)) dut (
      .sdram_clk     (clk),
      .sdram_rst     (rst),
      .p_acc_i       (p_acc),
      .p_we_i        (p_we),
      .p_adr_i       (p_adr),
      .p_dat_i       (p_dat),
      .p_sel_i       (p_sel),
      .p_buf_width_i (p_bw),
      .p_ack_o       (p_ack_o),
      .p_dat_o       (p_dat_o),
      .p_adr_o       (p_adr_o),
      .acc_o         (acc_o),
      .we_o          (we_o),
      .adr_o         (adr_o),
      .dat_o         (dat_o),
      .sel_o         (sel_o),
      .buf_width_o   (buf_width_o),
      .ack_i         (ack_i),
      .dat_i         (dat_i),
      .adr_i         (adr_i),
      .bufw_adr_o    (bufw_adr_o),
      .bufw_dat_o    (bufw_dat_o),
      .bufw_sel_o    (bufw_sel_o),
      .bufw_we_o     (bufw_we_o),
      .grant_o       (grant_o)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Behavioural model: who owns the controller, whether we are in the
   // post-release gap, and the pending snoop broadcast.
   int          m_owner;   // -1 when nobody owns the controller
   bit          m_gap;
   int          m_last;
   int          m_grant;
   bit          m_we;
   logic [N-1:0] m_mask;
   logic [31:0] m_badr, m_bdat;
   logic [3:0]  m_bsel;

   task automatic model_reset();
      m_owner = -1;
      m_gap   = 1'b0;
      m_last  = N - 1;
      m_grant = 0;
      m_we    = 1'b0;
      m_mask  = '0;
   endtask

   // Advance the model by one clock using the inputs currently applied.
   task automatic model_step();
      logic [N-1:0] nm;
      bit           found;
      bit           rel;
      int           p;
      nm    = '0;
      found = 1'b0;
      rel   = 1'b0;
      if (rst) begin
         model_reset();
         return;
      end
      if (m_gap) begin
         m_gap = 1'b0;
      end else if (m_owner < 0) begin
         for (int k = 1; k <= N; k++) begin
            p = (m_last + k) % N;
            if (!found && a_req[p]) begin
               found   = 1'b1;
               m_owner = p;
               m_grant = p;
               m_we    = a_we[p];
            end
         end
      end else begin
         if (!a_req[m_owner]) begin
            rel = 1'b1;
         end else if (m_we && ack_i) begin
            nm     = ~(N'(1) << m_owner);
            m_badr = a_adr[m_owner];
            m_bdat = a_dat[m_owner];
            m_bsel = a_sel[m_owner];
            rel    = 1'b1;
         end
         if (rel) begin
            m_last  = m_owner;
            m_owner = -1;
            m_gap   = 1'b1;
            m_we    = 1'b0;
         end
      end
      m_mask = nm;
   endtask

   // Compare every observable output with the model for the current cycle.
   task automatic sample();
      logic [N-1:0] e_ack;
      #1;
      e_ack = '0;
      if (m_owner >= 0 && ack_i) e_ack = N'(1) << m_owner;
      check("acc_o", 32'(acc_o), (m_owner >= 0) ? 32'd1 : 32'd0);
      check("we_o", 32'(we_o), (m_owner >= 0 && m_we) ? 32'd1 : 32'd0);
      check("grant_o", 32'(grant_o), 32'(m_grant));
      check("p_ack_o", 32'(p_ack_o), 32'(e_ack));
      check("p_dat_o", p_dat_o, dat_i);
      check("p_adr_o", p_adr_o, adr_i);
      if (m_owner >= 0) begin
         check("adr_o", adr_o, a_adr[m_owner]);
         check("dat_o", dat_o, a_dat[m_owner]);
         check("sel_o", 32'(sel_o), 32'(a_sel[m_owner]));
         check("buf_width_o", 32'(buf_width_o), 32'(a_bw[m_owner]));
      end
`ifdef WB_PORT_ARBITER_BUFW_EN
      check("bufw_we_o", 32'(bufw_we_o), 32'(m_mask));
      if (m_mask != '0) begin
         check("bufw_adr_o", bufw_adr_o, m_badr);
         check("bufw_dat_o", bufw_dat_o, m_bdat);
         check("bufw_sel_o", 32'(bufw_sel_o), 32'(m_bsel));
      end
`else
      check("bufw_we_o", 32'(bufw_we_o), 32'd0);
      check("bufw_payload", bufw_adr_o | bufw_dat_o | 32'(bufw_sel_o), 32'd0);
`endif
   endtask

   task automatic advance();
      model_step();
      @(posedge clk);
      #2;
   endtask

   int          ack_cnt;
   int          exp_order[4];

   initial begin
      rst   = 1'b1;
      ack_i = 1'b0;
      dat_i = '0;
      adr_i = '0;
      for (int i = 0; i < N; i++) begin
         a_req[i] = 1'b0;
         a_we[i]  = 1'b0;
         a_adr[i] = 32'h1000 * (i + 1);
         a_dat[i] = 32'hA000_0000 + i;
         a_sel[i] = 4'hF;
         a_bw[i]  = 4'd0;
         left_acks[i] = 0;
      end
      model_reset();
      repeat (2) @(posedge clk);
      #2;

      // Reset values
      sample();
      check("rst_acc", 32'(acc_o), 32'd0);
      check("rst_we", 32'(we_o), 32'd0);
      check("rst_grant", 32'(grant_o), 32'd0);
      check("rst_bufw_we", 32'(bufw_we_o), 32'd0);
      advance();
      rst = 1'b0;

      // Port 0 read burst of 8 words
      a_bw[0]  = 4'd3;
      a_adr[0] = 32'h0000_0040;
      a_req[0] = 1'b1;
      sample();
      check("t1_acc_before", 32'(acc_o), 32'd0);
      advance();
      sample();
      check("t1_acc_1cyc", 32'(acc_o), 32'd1);
      check("t1_grant", 32'(grant_o), 32'd0);
      check("t1_bw", 32'(buf_width_o), 32'd3);
      advance();
      ack_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         ack_i = 1'b1;
         dat_i = $urandom;
         adr_i = 32'h40 + 32'(i * 4);
         sample();
         if (p_ack_o[0]) ack_cnt++;
         check("t1_ack_route", 32'(p_ack_o), 32'd1);
         advance();
      end
      check("t1_ack_count", 32'(ack_cnt), 32'd8);
      ack_i    = 1'b0;
      a_req[0] = 1'b0;
      sample();
      check("t1_acc_hold", 32'(acc_o), 32'd1);
      advance();
      sample();
      check("t1_acc_drop", 32'(acc_o), 32'd0);
      advance();

      // Port 1 write with snoop broadcast
      a_req[1] = 1'b1;
      a_we[1]  = 1'b1;
      a_adr[1] = 32'h0000_0100;
      a_dat[1] = 32'hDEAD_BEEF;
      a_sel[1] = 4'hF;
      sample();
      advance();
      sample();
      check("t2_we", 32'(we_o), 32'd1);
      check("t2_adr", adr_o, 32'h0000_0100);
      check("t2_grant", 32'(grant_o), 32'd1);
      advance();
      ack_i = 1'b1;
      sample();
      check("t2_ack_route", 32'(p_ack_o), 32'b010);
      advance();
      ack_i    = 1'b0;
      a_req[1] = 1'b0;
      a_we[1]  = 1'b0;
      sample();
      check("t2_acc_drop", 32'(acc_o), 32'd0);
`ifdef WB_PORT_ARBITER_BUFW_EN
      check("t2_bufw_we", 32'(bufw_we_o), 32'b101);
      check("t2_bufw_adr", bufw_adr_o, 32'h0000_0100);
      check("t2_bufw_dat", bufw_dat_o, 32'hDEAD_BEEF);
      check("t2_bufw_sel", 32'(bufw_sel_o), 32'hF);
`else
      check("t2_bufw_we", 32'(bufw_we_o), 32'd0);
`endif
      advance();
      sample();
      check("t2_bufw_pulse", 32'(bufw_we_o), 32'd0);
      advance();

      // Continuous requests from all ports: strict rotation 0,1,2,0
      rst = 1'b1;
      sample();
      advance();
      rst = 1'b0;
      exp_order[0] = 0;
      exp_order[1] = 1;
      exp_order[2] = 2;
      exp_order[3] = 0;
      for (int i = 0; i < N; i++) begin
         a_req[i] = 1'b1;
         a_we[i]  = 1'b1;
         a_adr[i] = 32'h200 + 32'(i * 16);
         a_dat[i] = 32'h5500_0000 + 32'(i);
      end
      ack_i = 1'b1;
      for (int c = 0; c < 12; c++) begin
         sample();
         if (c % 3 == 1) begin
            check("t3_order", 32'(grant_o), 32'(exp_order[c / 3]));
            check("t3_acc", 32'(acc_o), 32'd1);
         end
         if (c % 3 == 2) check("t3_gap", 32'(acc_o), 32'd0);
         advance();
      end
      ack_i = 1'b0;
      for (int i = 0; i < N; i++) begin
         a_req[i] = 1'b0;
         a_we[i]  = 1'b0;
      end
      sample();
      advance();
      sample();
      advance();

      // Spurious ack while idle
      ack_i = 1'b1;
      sample();
      check("t4_ack_idle", 32'(p_ack_o), 32'd0);
      advance();
      ack_i = 1'b0;
      sample();
      check("t4_no_grant", 32'(acc_o), 32'd0);
      check("t4_grant_hold", 32'(grant_o), 32'd0);
      advance();

      // Reset in the middle of a write grant
      a_req[2] = 1'b1;
      a_we[2]  = 1'b1;
      sample();
      advance();
      sample();
      check("t5_grant", 32'(grant_o), 32'd2);
      ack_i = 1'b1;
      rst   = 1'b1;
      sample();
      advance();
      ack_i    = 1'b0;
      rst      = 1'b0;
      a_req[2] = 1'b0;
      a_we[2]  = 1'b0;
      sample();
      check("t5_acc_rst", 32'(acc_o), 32'd0);
      check("t5_bufw_rst", 32'(bufw_we_o), 32'd0);
      for (int i = 0; i < N; i++) a_req[i] = 1'b1;
      advance();
      sample();
      check("t5_port0_first", 32'(grant_o), 32'd0);
      for (int i = 0; i < N; i++) a_req[i] = 1'b0;
      advance();
      sample();
      advance();

      // Random traffic against the model
      for (int cyc = 0; cyc < 3000; cyc++) begin
         rst = ($urandom_range(0, 299) == 0);
         for (int p = 0; p < N; p++) begin
            if (!a_req[p] && $urandom_range(0, 3) == 0) begin
               a_req[p]     = 1'b1;
               a_we[p]      = 1'($urandom_range(0, 1));
               a_adr[p]     = $urandom;
               a_dat[p]     = $urandom;
               a_sel[p]     = 4'($urandom);
               a_bw[p]      = 4'($urandom);
               left_acks[p] = $urandom_range(1, 4);
            end else if (a_req[p] && $urandom_range(0, 49) == 0) begin
               a_req[p] = 1'b0;
            end
         end
         if (m_owner >= 0) ack_i = 1'($urandom_range(0, 1));
         else              ack_i = ($urandom_range(0, 5) == 0);
         dat_i = $urandom;
         adr_i = $urandom;
         sample();
         for (int p = 0; p < N; p++) begin
            done_f[p] = 1'b0;
            if (m_owner == p && ack_i && a_req[p]) begin
               if (a_we[p]) begin
                  done_f[p] = 1'b1;
               end else begin
                  left_acks[p]--;
                  if (left_acks[p] <= 0) done_f[p] = 1'b1;
               end
            end
         end
         advance();
         for (int p = 0; p < N; p++) begin
            if (done_f[p]) a_req[p] = 1'b0;
         end
      end

      rst   = 1'b0;
      ack_i = 1'b0;
      for (int i = 0; i < N; i++) a_req[i] = 1'b0;
      repeat (4) begin
         sample();
         advance();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
